// File: rtl/store_align_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_align_buffer_if
// Brief    : Store-request and memory-port bundle for store_align_buffer.
// Revision : 1.0  initial release
// ============================================================================
interface store_align_buffer_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 32
);
    logic             st_valid;
    logic             st_ready;
    logic [1:0]       st_size;
    logic [ASIZE-1:0] st_addr;
    logic [DSIZE-1:0] st_data;
    logic             st_err;
    logic             mem_req;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic             buf_empty;

    // MEM stage plus memory side, as seen from outside the buffer
    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, buf_empty
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, buf_empty
    );
endinterface
`default_nettype wire

// File: rtl/store_align_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_align_buffer
// Brief    : Lane-aligns byte/half/word stores and queues them for memory.
// Revision : 1.0  initial release
// ============================================================================
module store_align_buffer #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 32,
    parameter int DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    store_align_buffer_if.slave bus
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [ASIZE-1:0] r_addrMem [DEPTH];
    logic [DSIZE-1:0] r_dataMem [DEPTH];
    logic [3:0]       r_beMem   [DEPTH];
    logic [c_PW-1:0]  r_wrPtr;
    logic [c_PW-1:0]  r_rdPtr;
    logic [c_CW-1:0]  r_count;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_misaligned;
    logic [1:0]       w_lane;
    logic [DSIZE-1:0] w_fmtData;
    logic [3:0]       w_fmtBe;
    logic [ASIZE-1:0] w_fmtAddr;

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.st_valid && !w_full;
    assign w_push   = w_accept && !w_misaligned;
    assign w_pop    = bus.mem_ack && !w_empty;
    assign w_lane   = bus.st_addr[1:0];
    assign w_fmtAddr = {bus.st_addr[ASIZE-1:2], 2'b00};

    // Replicate the low bits across lanes so the enable mask alone picks the target bytes
    always_comb begin
        w_fmtData    = '0;
        w_fmtBe      = 4'b0000;
        w_misaligned = 1'b1;
        case (bus.st_size)
            2'b00: begin
                w_fmtData    = {4{bus.st_data[7:0]}};
                w_fmtBe      = 4'b0001 << w_lane;
                w_misaligned = 1'b0;
            end
            2'b01: begin
                w_fmtData    = {2{bus.st_data[15:0]}};
                w_fmtBe      = w_lane[1] ? 4'b1100 : 4'b0011;
                w_misaligned = w_lane[0];
            end
            2'b10: begin
                w_fmtData    = bus.st_data;
                w_fmtBe      = 4'b1111;
                w_misaligned = |w_lane;
            end
            default: begin
                w_misaligned = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && w_misaligned;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addrMem[r_wrPtr] <= w_fmtAddr;
            r_dataMem[r_wrPtr] <= w_fmtData;
            r_beMem[r_wrPtr]   <= w_fmtBe;
        end
    end

    assign bus.st_ready  = !w_full;
    assign bus.st_err    = r_err;
    assign bus.mem_req   = !w_empty;
    assign bus.buf_empty = w_empty;
    assign bus.mem_addr  = w_empty ? '0 : r_addrMem[r_rdPtr];
    assign bus.mem_wdata = w_empty ? '0 : r_dataMem[r_rdPtr];
    assign bus.mem_be    = w_empty ? 4'b0000 : r_beMem[r_rdPtr];
endmodule
`default_nettype wire

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the immediate/load extension path: narrows and lane-aligns register data for byte/halfword/word stores.
- Sits between the MEM stage and the data memory port.
- Accepts store requests with a valid/ready handshake, formats them at enqueue into word-aligned address, replicated lane data and byte enables, and queues them in a small FIFO.
- Drains the FIFO to memory with a req/ack handshake; misaligned stores are flagged and dropped.

Parameters:
- DSize, 32, data word width; fixed at 32, with 4 byte lanes.
- ASize, 32, byte address width.
- Depth, 2, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request valid from MEM stage.
- st_ready  output  1  buffer can accept a request this cycle.
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- st_addr  input  ASize  byte address.
- st_data  input  DSize  register data; the low bits carry the value.
- st_err  output  1  one-cycle pulse: previous accepted store was misaligned or illegal.
- mem_req  output  1  head entry valid for memory.
- mem_addr  output  ASize  word-aligned address, low 2 bits always 0.
- mem_wdata  output  DSize  lane-replicated write data.
- mem_be  output  4  byte enables; bit i enables bits [8i+7:8i].
- mem_ack  input  1  memory accepted the head entry.
- buf_empty  output  1  no pending entries; used by the hazard unit for load ordering.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and count cleared; all pending entries discarded, including one being presented with mem_req.
  - Outputs after reset: st_ready=1, st_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, buf_empty=1.
  - st_valid and mem_ack are ignored in any cycle where rst=1.
- Accept rules:
  - st_ready = !full, a function of registered count only, not of mem_ack.
  - A request is accepted when st_valid && st_ready.
  - A full FIFO does not accept in the same cycle it pops.
- Formatting at accept (little-endian, a = st_addr[1:0]):
  - Byte: wdata = {4{st_data[7:0]}}; be = 4'b0001 << a.
  - Halfword: wdata = {2{st_data[15:0]}}; be = a[1] ? 4'b1100 : 4'b0011; misaligned if a[0]=1.
  - Word: wdata = st_data; be = 4'b1111; misaligned if a != 0.
  - Size 11: illegal, treated as misaligned.
  - Stored address = {st_addr[ASize-1:2], 2'b00}.
- Error path: a misaligned or illegal accepted request is consumed but not enqueued. st_err is 1 for exactly the next cycle; the FIFO is unchanged.
- Memory side:
  - mem_req = !empty.
  - mem_addr, mem_wdata and mem_be show the head entry and stay stable while mem_req && !mem_ack.
  - mem_ack with mem_req=1 pops the head at the edge.
  - mem_ack with mem_req=0 is ignored.
- FIFO pointers:
  - Read/write pointers are log2(Depth) bits and wrap modulo Depth.
  - count is 0..Depth; full = (count==Depth), empty = (count==0).
  - Push and pop in the same cycle (non-full, non-empty): count unchanged, both pointers advance.
  - Push into an empty FIFO: entry visible on mem_req the next cycle (1-cycle latency, no bypass).
- When empty, mem_addr, mem_wdata and mem_be drive 0.
- buf_empty = empty, registered-state derived.
- Ordering: strict FIFO; memory sees stores in accept order.

Test Plan:
- Reset, then idle → st_ready=1, mem_req=0, buf_empty=1, mem_be=0.
- Byte store, addr 0x103, data 0x000000A5 → next cycle mem_req=1, mem_addr=0x100, mem_wdata=0xA5A5A5A5, mem_be=4'b1000; ack → buf_empty=1.
- Halfword at 0x202, data 0x1234BEEF → mem_wdata=0xBEEFBEEF, mem_be=4'b1100. Then halfword at 0x201 → st_err pulses 1 cycle, no enqueue, count unchanged.
- Back-to-back word stores 0x10, 0x14, 0x18 with mem_ack=0 → st_ready drops after 2 accepts. Third held; ack once → third accepted next cycle. Memory sees 0x10, 0x14, 0x18 in order; pointers wrap.
- Steady stream with mem_ack=1 each cycle and one push per cycle → count stays 1, mem_req continuously 1, no drops.
- Fill with 2 entries, assert rst with mem_ack=1 in the same cycle → after the edge, mem_req=0, buf_empty=1, neither entry popped to memory.
